rx_peak_readout_scheduler: RTL and testbench

RX_PEAK_READOUT_SCHEDULER -- requirements
Module: rx_peak_readout_scheduler

---
 rtl/rx_peak_readout_scheduler_pkg.sv | 29 ++
 rtl/rx_rr_arbiter4.sv | 32 +++
 rtl/rx_peak_readout_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_rx_peak_readout_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_peak_readout_scheduler_pkg.sv
// Shared definitions for the RX peak readout path: datapath widths, FSM state
// encoding and the record latched for ARM.
`timescale 1ns/1ps
package rx_peak_readout_scheduler_pkg;

  localparam int CORR_W  = 41;
  localparam int TIME_W  = 16;
  localparam int NUM_GRP = 4;
  localparam int SEQ_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HOLD    = 2'd3
  } rx_state_e;

  // Everything ARM sees for one peak, captured together at the end of GRANT.
  typedef struct packed {
    logic [CORR_W-1:0] peak;
    logic [SEQ_W-1:0]  seq;
    logic [TIME_W-1:0] ts;
  } rx_readout_t;

  function automatic logic [NUM_GRP-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rx_rr_arbiter4.sv
// Four-way round-robin selector: first asserted request at or after the
// pointer, searching upward with wrap-around.
`timescale 1ns/1ps
module rx_rr_arbiter4
  import rx_peak_readout_scheduler_pkg::*;
(
  input  logic [NUM_GRP-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_GRP-1:0] gnt,
  output logic [1:0]         idx
);

  always_comb begin : search
    logic [1:0] cand;
    logic       found;
    // NOTE: every output and temporary gets a default before any branch, so no
    // path through the block leaves a value held and no latch is inferred.
    gnt   = '0;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_GRP; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) gnt = onehot4(idx);
  end

endmodule

// File: rtl/rx_peak_readout_scheduler.sv
// Serves peak candidates from four correlator buffer groups to ARM one at a
// time, with per-transaction ack timeout and a guard interval between grants.
`timescale 1ns/1ps
module rx_peak_readout_scheduler
  import rx_peak_readout_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ARM_TIMEOUT = 1023
) (
  input  logic                     crx_clk,
  input  logic                     rrx_rst,
  input  logic                     erx_en,
  input  logic                     inew_samle_trigger,
  input  logic [NUM_GRP-1:0]       ireq,
  input  logic signed [CORR_W-1:0] ipeak_0,
  input  logic signed [CORR_W-1:0] ipeak_1,
  input  logic signed [CORR_W-1:0] ipeak_2,
  input  logic signed [CORR_W-1:0] ipeak_3,
  input  logic [1:0]               iseq_0,
  input  logic [1:0]               iseq_1,
  input  logic [1:0]               iseq_2,
  input  logic [1:0]               iseq_3,
  output logic [NUM_GRP-1:0]       ogrant,
  output logic signed [CORR_W-1:0] o_sample_arm,
  output logic [SEQ_W-1:0]         o_received_seq,
  output logic [TIME_W-1:0]        o_time_arm,
  output logic                     o_trigger_arm,
  input  logic                     iarm_ack,
  output logic                     o_timeout
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TMO_W  = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ARM_TIMEOUT - 1);

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  rx_state_e          state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         gidx_q, gidx_d;
  logic [TIME_W-1:0]  ts_q, ts_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [NUM_GRP-1:0] ogrant_q, ogrant_d;
  logic               trig_q, trig_d;
  logic               timeout_q, timeout_d;
  rx_readout_t        out_q, out_d;

  logic [NUM_GRP-1:0] arb_gnt;
  logic [1:0]         arb_idx;
  logic [CORR_W-1:0]  sel_peak;
  logic [1:0]         sel_seq;

  rx_rr_arbiter4 u_arb (
    .req (ireq),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    sel_peak = ipeak_0;
    sel_seq  = iseq_0;
    case (gidx_q)
      2'd1:    begin sel_peak = ipeak_1; sel_seq = iseq_1; end
      2'd2:    begin sel_peak = ipeak_2; sel_seq = iseq_2; end
      2'd3:    begin sel_peak = ipeak_3; sel_seq = iseq_3; end
      default: ;
    endcase
  end

  // The counter's current value is what a same-cycle GRANT latches.
  always_comb begin
    ts_d = ts_q;
    if (erx_en && inew_samle_trigger) ts_d = ts_q + TIME_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    hold_cnt_d = hold_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    ogrant_d   = '0;
    trig_d     = 1'b0;
    timeout_d  = 1'b0;
    out_d      = out_q;

    if (!erx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ireq != '0) begin
            state_d  = ST_GRANT;
            gidx_d   = arb_idx;
            ogrant_d = arb_gnt;
          end
        end
        ST_GRANT: begin
          if (ireq[gidx_q]) begin
            out_d.peak = sel_peak;
            out_d.seq  = {gidx_q, sel_seq};
            out_d.ts   = ts_q;
            rr_ptr_d   = gidx_q + 2'd1;
            tmo_cnt_d  = '0;
            trig_d     = 1'b1;
            state_d    = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (iarm_ack) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            trig_d    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
          else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge crx_clk or negedge rst_n) begin
    // NOTE: the data registers are cleared as well, because the outputs they
    // drive must read zero while reset is held.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      ts_q       <= '0;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      ogrant_q   <= '0;
      trig_q     <= 1'b0;
      timeout_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      ts_q       <= ts_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ogrant_q   <= ogrant_d;
      trig_q     <= trig_d;
      timeout_q  <= timeout_d;
      out_q      <= out_d;
    end
  end

  assign ogrant         = ogrant_q;
  assign o_sample_arm   = $signed(out_q.peak);
  assign o_received_seq = out_q.seq;
  assign o_time_arm     = out_q.ts;
  assign o_trigger_arm  = trig_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_rx_peak_readout_scheduler.sv
// Randomized scoreboard bench for rx_peak_readout_scheduler: a driver queues
// expected readouts from a round-robin reference model, a monitor checks them.
`timescale 1ns/1ps
module tb_rx_peak_readout_scheduler;
  import rx_peak_readout_scheduler_pkg::*;

  localparam int HOLD     = 4;
  localparam int TMO      = 1023;
  localparam int ACK_RAND = 0;
  localparam int ACK_ONE  = 1;
  localparam int ACK_NONE = 2;

  logic crx_clk = 1'b0;
  logic rrx_rst = 1'b0;
  logic erx_en = 1'b0;
  logic inew_samle_trigger = 1'b0;
  logic iarm_ack = 1'b0;
  logic [3:0] ireq = '0;
  logic signed [CORR_W-1:0] peak_r [4];
  logic [1:0] seq_r [4];

  logic [3:0]               ogrant;
  logic signed [CORR_W-1:0] o_sample_arm;
  logic [3:0]               o_received_seq;
  logic [TIME_W-1:0]        o_time_arm;
  logic                     o_trigger_arm;
  logic                     o_timeout;

  rx_peak_readout_scheduler #(.HOLD_CYCLES(HOLD), .ARM_TIMEOUT(TMO)) dut (
    .crx_clk            (crx_clk),
    .rrx_rst            (rrx_rst),
    .erx_en             (erx_en),
    .inew_samle_trigger (inew_samle_trigger),
    .ireq               (ireq),
    .ipeak_0            (peak_r[0]),
    .ipeak_1            (peak_r[1]),
    .ipeak_2            (peak_r[2]),
    .ipeak_3            (peak_r[3]),
    .iseq_0             (seq_r[0]),
    .iseq_1             (seq_r[1]),
    .iseq_2             (seq_r[2]),
    .iseq_3             (seq_r[3]),
    .ogrant             (ogrant),
    .o_sample_arm       (o_sample_arm),
    .o_received_seq     (o_received_seq),
    .o_time_arm         (o_time_arm),
    .o_trigger_arm      (o_trigger_arm),
    .iarm_ack           (iarm_ack),
    .o_timeout          (o_timeout)
  );

  always #5 crx_clk = ~crx_clk;

  typedef struct {
    logic signed [CORR_W-1:0] peak;
    logic [3:0]               seq;
    logic [TIME_W-1:0]        ts;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ack_mode = ACK_ONE;
  int          ptr_m = 0;
  logic [15:0] ts_m = '0;

  always @(posedge crx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ogrant"}, ogrant, 0);
    check({tag, "_trigger"}, o_trigger_arm, 0);
    check({tag, "_timeout"}, o_timeout, 0);
    check({tag, "_sample"}, o_sample_arm, 0);
    check({tag, "_seq"}, o_received_seq, 0);
    check({tag, "_time"}, o_time_arm, 0);
  endtask

  // ARM side: acknowledges after a delay chosen by ack_mode; in random mode it
  // also throws stray acks while nothing is presented.
  initial begin : responder
    int wcnt, tgt;
    bit done;
    wcnt = 0; tgt = 0; done = 1'b0;
    forever begin
      @(negedge crx_clk);
      iarm_ack = 1'b0;
      if (o_trigger_arm) begin
        if (!done && ack_mode != ACK_NONE) begin
          if (wcnt == tgt) begin iarm_ack = 1'b1; done = 1'b1; end
          else wcnt++;
        end
      end else begin
        done = 1'b0;
        wcnt = 0;
        tgt  = (ack_mode == ACK_ONE) ? 1 : int'($urandom_range(0, 3));
        if (ack_mode == ACK_RAND && $urandom_range(0, 7) == 0) iarm_ack = 1'b1;
      end
    end
  end

  bit         m_prev_trig = 1'b0;
  bit         m_acked = 1'b0;
  bit         m_rise_valid = 1'b0;
  bit         m_grant_valid = 1'b0;
  logic [3:0] m_prev_grant = '0;
  int         m_len = 0;
  int         m_last_rise = 0;
  int         m_last_grant = 0;

  initial begin : monitor
    exp_t       e;
    logic [3:0] exp_gnt;
    forever begin
      @(posedge crx_clk);
      #1;
      if (!rrx_rst) begin
        m_prev_trig = 1'b0; m_acked = 1'b0; m_rise_valid = 1'b0;
        m_grant_valid = 1'b0; m_prev_grant = '0; m_len = 0;
        continue;
      end
      if (!erx_en) m_rise_valid = 1'b0;
      if (m_prev_trig && iarm_ack) m_acked = 1'b1;

      if (ogrant != '0) begin
        check("grant_single_cycle", m_prev_grant, 0);
        if (sb.size() > 0) begin
          exp_gnt = 4'b0001 << sb[0].seq[3:2];
          check("grant_onehot", ogrant, exp_gnt);
        end else begin
          check("grant_unexpected", ogrant, 0);
        end
        m_last_grant  = cyc;
        m_grant_valid = 1'b1;
      end

      if (o_trigger_arm && !m_prev_trig) begin
        check("trigger_after_grant", m_grant_valid ? 64'(cyc - m_last_grant) : 64'd0, 1);
        if (m_rise_valid) check("trigger_spacing", 64'((cyc - m_last_rise) >= HOLD + 3), 1);
        m_last_rise  = cyc;
        m_rise_valid = 1'b1;
        if (sb.size() == 0) begin
          check("trigger_unexpected", o_trigger_arm, 0);
        end else begin
          e = sb.pop_front();
          check("sample_arm", o_sample_arm, e.peak);
          check("received_seq", o_received_seq, e.seq);
          check("time_arm", o_time_arm, e.ts);
        end
        m_acked = 1'b0;
        m_len   = 0;
      end
      if (o_trigger_arm) m_len++;

      if (!o_trigger_arm && m_prev_trig) begin
        check("timeout_pulse", o_timeout, 64'(!m_acked && m_len == TMO));
      end else if (o_timeout) begin
        check("timeout_stray", o_timeout, 0);
      end
      m_prev_trig  = o_trigger_arm;
      m_prev_grant = ogrant;
    end
  end

  // Queues the round-robin service order for mask, then holds each request
  // until its grant has been seen.
  task automatic serve_mask(input logic [3:0] mask, input bit pulse_on_grant);
    logic [3:0] pending, clr;
    int         budget, last_k;
    exp_t       e;
    last_k = ptr_m;
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (ptr_m + j) % 4;
      if (mask[k]) begin
        e.peak = peak_r[k];
        e.seq  = {2'(k), seq_r[k]};
        e.ts   = ts_m;
        sb.push_back(e);
        last_k = k;
      end
    end
    ptr_m = (last_k + 1) % 4;
    @(negedge crx_clk);
    ireq = mask; pending = mask; clr = '0; budget = 0;
    while ((pending != '0 || clr != '0) && budget < 5000) begin
      @(negedge crx_clk);
      budget++;
      inew_samle_trigger = 1'b0;
      ireq    = ireq & ~clr;
      pending = pending & ~clr;
      clr     = ogrant & ireq;
      if (pulse_on_grant && ogrant != '0) begin
        inew_samle_trigger = 1'b1;
        ts_m++;
      end
    end
    if (pending != '0) begin
      check("serve_budget", pending, 0);
      ireq = '0;
    end
  endtask

  task automatic wait_trig(input logic lvl, input int max);
    int n;
    n = 0;
    while (o_trigger_arm !== lvl && n < max) begin
      @(negedge crx_clk);
      n++;
    end
    if (o_trigger_arm !== lvl) check("wait_trigger", o_trigger_arm, lvl);
  endtask

  task automatic pulse_ts(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge crx_clk); inew_samle_trigger = 1'b1;
      @(negedge crx_clk); inew_samle_trigger = 1'b0;
      ts_m++;
    end
  endtask

  task automatic hold_ts(input int n);
    @(negedge crx_clk);
    inew_samle_trigger = 1'b1;
    repeat (n) @(negedge crx_clk);
    inew_samle_trigger = 1'b0;
    ts_m = ts_m + 16'(n);
  endtask

  task automatic randomize_groups();
    logic [63:0] r;
    for (int k = 0; k < 4; k++) begin
      r = {$urandom(), $urandom()};
      peak_r[k] = r[CORR_W-1:0];
      seq_r[k]  = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin : driver
    logic signed [CORR_W-1:0] held_peak;
    exp_t e;
    for (int k = 0; k < 4; k++) begin peak_r[k] = '0; seq_r[k] = '0; end

    // Reset state.
    erx_en = 1'b1;
    repeat (3) @(negedge crx_clk);
    check_all_zero("reset");
    rrx_rst = 1'b1;
    repeat (4) @(negedge crx_clk);

    // Single group 0 at timestamp 100.
    hold_ts(100);
    randomize_groups();
    peak_r[0] = -41'sd5;
    seq_r[0]  = 2'd2;
    serve_mask(4'b0001, 1'b0);
    wait_trig(1'b0, 100);

    // Random masks, data and timestamp activity.
    ack_mode = ACK_RAND;
    for (int r = 0; r < 30; r++) begin
      randomize_groups();
      pulse_ts($urandom_range(0, 3));
      serve_mask(4'($urandom_range(1, 15)), 1'b0);
    end
    wait_trig(1'b0, 100);

    // ARM never answers: timeout, then the next request is still served.
    ack_mode = ACK_NONE;
    randomize_groups();
    serve_mask(4'b1000, 1'b0);
    wait_trig(1'b1, 50);
    wait_trig(1'b0, TMO + 50);
    ack_mode = ACK_RAND;
    randomize_groups();
    serve_mask(4'b0011, 1'b0);
    wait_trig(1'b0, 100);

    // Receiver disabled while presenting.
    ack_mode = ACK_NONE;
    randomize_groups();
    held_peak = peak_r[2];
    serve_mask(4'b0100, 1'b0);
    wait_trig(1'b1, 50);
    erx_en = 1'b0;
    @(negedge crx_clk);
    check("en_drop_trigger", o_trigger_arm, 0);
    check("en_drop_ogrant", ogrant, 0);
    check("en_drop_sample_held", o_sample_arm, held_peak);
    repeat (2) @(negedge crx_clk);
    erx_en = 1'b1;
    ack_mode = ACK_RAND;

    // Reset asserted during GRANT.
    randomize_groups();
    e.peak = peak_r[1]; e.seq = {2'd1, seq_r[1]}; e.ts = ts_m;
    sb.push_back(e);
    @(negedge crx_clk);
    ireq = 4'b0010;
    for (int n = 0; n < 50 && ogrant == '0; n++) @(negedge crx_clk);
    check("reset_test_grant_seen", ogrant, 4'b0010);
    rrx_rst = 1'b0;
    #1;
    check_all_zero("abort");
    sb.delete();
    ptr_m = 0;
    ts_m  = '0;
    ireq  = '0;
    repeat (3) @(negedge crx_clk);
    rrx_rst = 1'b1;
    repeat (4) @(negedge crx_clk);

    // All groups requesting, ack one cycle after each trigger: order 0,1,2,3,0.
    ack_mode = ACK_ONE;
    randomize_groups();
    serve_mask(4'b1111, 1'b0);
    randomize_groups();
    serve_mask(4'b0001, 1'b0);
    wait_trig(1'b0, 100);

    // Timestamp at 65535 with a sample tick in the GRANT cycle, then wrapped.
    ack_mode = ACK_RAND;
    hold_ts(65535 - int'(ts_m));
    randomize_groups();
    serve_mask(4'b0100, 1'b1);
    randomize_groups();
    serve_mask(4'b0010, 1'b0);
    wait_trig(1'b0, 100);
    repeat (HOLD + 4) @(negedge crx_clk);
    check("scoreboard_drained", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
